// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helper for the IFU/LSU memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_e;
    typedef enum logic {OWN_IFU, OWN_LSU} owner_e;

    // Width of the latency down-counter; never narrower than one bit.
    function automatic int lat_cnt_w(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of the IFU, LSU and memory-side signals of the arbiter.
interface mem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic              ifu_resp_ready;
    logic [DATA_W-1:0] ifu_rdata;

    logic                lsu_req_valid;
    logic                lsu_req_ready;
    logic                lsu_wr;
    logic [ADDR_W-1:0]   lsu_addr;
    logic [DATA_W-1:0]   lsu_wdata;
    logic [DATA_W/8-1:0] lsu_wstrb;
    logic                lsu_resp_valid;
    logic                lsu_resp_ready;
    logic [DATA_W-1:0]   lsu_rdata;

    logic                mem_en;
    logic                mem_wr;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic [DATA_W-1:0]   mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr, ifu_resp_ready,
        input  lsu_req_valid, lsu_wr, lsu_addr, lsu_wdata, lsu_wstrb, lsu_resp_ready,
        input  mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_en, mem_wr, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output ifu_req_valid, ifu_addr, ifu_resp_ready,
        output lsu_req_valid, lsu_wr, lsu_addr, lsu_wdata, lsu_wstrb, lsu_resp_ready,
        output mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_en, mem_wr, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_arb_grant.sv
// Tie-break between IFU and LSU requests. Fixed LSU priority by default;
// with MEM_ARB_RR_EN defined, a tie goes to the side not granted last.
module mem_arb_grant
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic clk,
    input  logic rst_n,
    input  logic grant_fire_i,
`endif
    input  logic ifu_req_i,
    input  logic lsu_req_i,
    output logic ifu_gnt_o,
    output logic lsu_gnt_o
);

`ifdef MEM_ARB_RR_EN
    owner_e last_q;
    owner_e last_d;

    // Reset as "LSU granted last" so the first tie after reset goes to IFU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= OWN_LSU;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        ifu_gnt_o = ifu_req_i & (~lsu_req_i | (last_q == OWN_LSU));
        lsu_gnt_o = lsu_req_i & (~ifu_req_i | (last_q == OWN_IFU));
        last_d    = last_q;
        if (grant_fire_i) begin
            last_d = lsu_gnt_o ? OWN_LSU : OWN_IFU;
        end
    end
`else
    always_comb begin
        ifu_gnt_o = ifu_req_i & ~lsu_req_i;
        lsu_gnt_o = lsu_req_i;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one combinational-read memory port between IFU and LSU, one transaction
// at a time, with LAT wait cycles before the access. Round-robin ties via MEM_ARB_RR_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    mem_arb_if.slave  bus
);

    localparam int LAT_CNT_W = lat_cnt_w(LAT);
    localparam int STRB_W    = DATA_W / 8;

    state_e               state_q, state_d;
    owner_e               owner_q, owner_d;
    logic                 wr_q, wr_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [STRB_W-1:0]    wstrb_q, wstrb_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;

    logic ifu_gnt;
    logic lsu_gnt;
    logic grant_fire;

    // Gating with rst_n keeps req_ready low while reset is asserted.
    assign grant_fire = (state_q == IDLE) && rst_n && (ifu_gnt || lsu_gnt);

    mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
        .clk          (clk),
        .rst_n        (rst_n),
        .grant_fire_i (grant_fire),
`endif
        .ifu_req_i    (bus.ifu_req_valid),
        .lsu_req_i    (bus.lsu_req_valid),
        .ifu_gnt_o    (ifu_gnt),
        .lsu_gnt_o    (lsu_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_IFU;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        owner_d           = owner_q;
        wr_d              = wr_q;
        addr_d            = addr_q;
        wdata_d           = wdata_q;
        wstrb_d           = wstrb_q;
        rdata_d           = rdata_q;
        cnt_d             = cnt_q;
        bus.ifu_req_ready = 1'b0;
        bus.lsu_req_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_fire) begin
                    bus.ifu_req_ready = ifu_gnt;
                    bus.lsu_req_ready = lsu_gnt;
                    owner_d = lsu_gnt ? OWN_LSU : OWN_IFU;
                    wr_d    = lsu_gnt & bus.lsu_wr;
                    addr_d  = lsu_gnt ? bus.lsu_addr : bus.ifu_addr;
                    wdata_d = lsu_gnt ? bus.lsu_wdata : '0;
                    wstrb_d = lsu_gnt ? bus.lsu_wstrb : '0;
                    cnt_d   = LAT_CNT_W'(LAT);
                    state_d = (LAT == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - LAT_CNT_W'(1);
                if (cnt_q <= LAT_CNT_W'(1)) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                rdata_d = wr_q ? '0 : bus.mem_rdata;
                state_d = RESP;
            end
            RESP: begin
                if ((owner_q == OWN_LSU && bus.lsu_resp_ready) ||
                    (owner_q == OWN_IFU && bus.ifu_resp_ready)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_en    = (state_q == ACCESS);
    assign bus.mem_wr    = wr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;

    assign bus.ifu_resp_valid = (state_q == RESP) && (owner_q == OWN_IFU);
    assign bus.lsu_resp_valid = (state_q == RESP) && (owner_q == OWN_LSU);
    assign bus.ifu_rdata      = (owner_q == OWN_IFU) ? rdata_q : '0;
    assign bus.lsu_rdata      = (owner_q == OWN_LSU) ? rdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: three instances with LAT = 1, 0 and 3.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        bit          lsu;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc_cnt = 0;
    int   prev_en = 0;
    int   last_en = 0;
    bit   last_lsu = 1'b1;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    mem_arb_if #(.ADDR_W(32), .DATA_W(32)) if1 ();
    mem_arb_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
    mem_arb_if #(.ADDR_W(32), .DATA_W(32)) if3 ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h1234_5678);
    endfunction

    assign if1.mem_rdata = mem_model(if1.mem_addr);
    assign if0.mem_rdata = mem_model(if0.mem_addr);
    assign if3.mem_rdata = mem_model(if3.mem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h required %h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b required %b", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one request on the LAT=1 instance and expect it to be granted this cycle.
    task automatic accept1(input bit lsu, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
        exp_t e;
        if (lsu) begin
            if1.lsu_req_valid = 1'b1;
            if1.lsu_wr        = wr;
            if1.lsu_addr      = addr;
            if1.lsu_wdata     = wdata;
            if1.lsu_wstrb     = wstrb;
        end else begin
            if1.ifu_req_valid = 1'b1;
            if1.ifu_addr      = addr;
        end
        @(negedge clk);
        chk1("acc_ready", lsu ? if1.lsu_req_ready : if1.ifu_req_ready, 1'b1);
        chk1("acc_other_ready", lsu ? if1.ifu_req_ready : if1.lsu_req_ready, 1'b0);
        e.lsu   = lsu;
        e.wr    = wr;
        e.addr  = addr;
        e.wdata = wdata;
        e.wstrb = wstrb;
        e.rdata = wr ? 32'h0 : mem_model(addr);
        sb.push_back(e);
        last_lsu = lsu;
    endtask

    // Follow the oldest accepted transaction through WAIT, ACCESS and RESP.
    task automatic finish1(input int hold, input bit raise_other);
        exp_t e;
        e = sb.pop_front();
        cyc();
        if (e.lsu) if1.lsu_req_valid = 1'b0; else if1.ifu_req_valid = 1'b0;
        if (raise_other) begin
            if (e.lsu) if1.ifu_req_valid = 1'b1; else if1.lsu_req_valid = 1'b1;
        end
        @(negedge clk);
        chk1("wait_mem_en", if1.mem_en, 1'b0);
        chk("wait_req_ready", 32'({if1.ifu_req_ready, if1.lsu_req_ready}), 32'h0);
        cyc();
        @(negedge clk);
        chk1("access_mem_en", if1.mem_en, 1'b1);
        chk1("access_mem_wr", if1.mem_wr, e.wr);
        chk("access_mem_addr", if1.mem_addr, e.addr);
        if (e.wr) begin
            chk("access_mem_wdata", if1.mem_wdata, e.wdata);
            chk("access_mem_wstrb", 32'(if1.mem_wstrb), 32'(e.wstrb));
        end
        chk("access_req_ready", 32'({if1.ifu_req_ready, if1.lsu_req_ready}), 32'h0);
        prev_en = last_en;
        last_en = cyc_cnt;
        cyc();
        if (hold > 0) begin
            if (e.lsu) if1.lsu_resp_ready = 1'b0; else if1.ifu_resp_ready = 1'b0;
        end
        @(negedge clk);
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) begin
                cyc();
                if (i == hold) begin
                    if1.lsu_resp_ready = 1'b1;
                    if1.ifu_resp_ready = 1'b1;
                end
                @(negedge clk);
            end
            chk1("resp_valid", e.lsu ? if1.lsu_resp_valid : if1.ifu_resp_valid, 1'b1);
            chk1("resp_other_valid", e.lsu ? if1.ifu_resp_valid : if1.lsu_resp_valid, 1'b0);
            chk("resp_rdata", e.lsu ? if1.lsu_rdata : if1.ifu_rdata, e.rdata);
            chk1("resp_mem_en", if1.mem_en, 1'b0);
            chk("resp_req_ready", 32'({if1.ifu_req_ready, if1.lsu_req_ready}), 32'h0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bit   w;
        if1.ifu_req_valid = 1'b0; if1.ifu_addr = '0; if1.ifu_resp_ready = 1'b1;
        if1.lsu_req_valid = 1'b0; if1.lsu_wr = 1'b0; if1.lsu_addr = '0;
        if1.lsu_wdata = '0; if1.lsu_wstrb = '0; if1.lsu_resp_ready = 1'b1;
        if0.ifu_req_valid = 1'b0; if0.ifu_addr = '0; if0.ifu_resp_ready = 1'b1;
        if0.lsu_req_valid = 1'b0; if0.lsu_wr = 1'b0; if0.lsu_addr = '0;
        if0.lsu_wdata = '0; if0.lsu_wstrb = '0; if0.lsu_resp_ready = 1'b1;
        if3.ifu_req_valid = 1'b0; if3.ifu_addr = '0; if3.ifu_resp_ready = 1'b1;
        if3.lsu_req_valid = 1'b0; if3.lsu_wr = 1'b0; if3.lsu_addr = '0;
        if3.lsu_wdata = '0; if3.lsu_wstrb = '0; if3.lsu_resp_ready = 1'b1;

        // Reset state, including a request held during reset
        if1.ifu_req_valid = 1'b1;
        #12;
        chk1("rst_ifu_req_ready", if1.ifu_req_ready, 1'b0);
        chk1("rst_mem_en", if1.mem_en, 1'b0);
        chk1("rst_ifu_resp_valid", if1.ifu_resp_valid, 1'b0);
        chk1("rst_lsu_resp_valid", if1.lsu_resp_valid, 1'b0);
        chk("rst_mem_addr", if1.mem_addr, 32'h0);
        chk("rst_ifu_rdata", if1.ifu_rdata, 32'h0);
        if1.ifu_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // IFU read, LAT=1
        cyc();
        accept1(1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
        finish1(0, 1'b0);

        // Response stalled 5 cycles while LSU waits, then LSU load
        cyc();
        if1.lsu_wr = 1'b0; if1.lsu_addr = 32'h8000_0010;
        accept1(1'b0, 1'b0, 32'h8000_0004, 32'h0, 4'h0);
        finish1(5, 1'b1);
        cyc();
        accept1(1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'h0);
        finish1(0, 1'b0);

        // Two ties in a row; loser must be served in the first IDLE afterwards
        for (int t = 0; t < 2; t++) begin
            cyc();
            w = RR ? !last_lsu : 1'b1;
            if1.ifu_req_valid = 1'b1; if1.ifu_addr = 32'h8000_0020 + 32'(t * 8);
            if1.lsu_req_valid = 1'b1; if1.lsu_wr = 1'b0; if1.lsu_addr = 32'h8000_0024 + 32'(t * 8);
            accept1(w, 1'b0, w ? if1.lsu_addr : if1.ifu_addr, 32'h0, 4'h0);
            finish1(0, 1'b0);
            cyc();
            accept1(!w, 1'b0, w ? if1.ifu_addr : if1.lsu_addr, 32'h0, 4'h0);
            finish1(0, 1'b0);
        end

        // LSU store then back-to-back IFU reads with resp_ready high
        cyc();
        accept1(1'b1, 1'b1, 32'h8000_0030, 32'hCAFE_F00D, 4'b1100);
        finish1(0, 1'b0);
        cyc();
        accept1(1'b0, 1'b0, 32'h8000_0040, 32'h0, 4'h0);
        finish1(0, 1'b0);
        cyc();
        accept1(1'b0, 1'b0, 32'h8000_0044, 32'h0, 4'h0);
        finish1(0, 1'b0);
        chk("b2b_mem_en_period", 32'(last_en - prev_en), 32'd4);

        // LAT=0 LSU store
        cyc();
        if0.lsu_req_valid = 1'b1; if0.lsu_wr = 1'b1; if0.lsu_addr = 32'h8000_0100;
        if0.lsu_wdata = 32'hDEAD_BEEF; if0.lsu_wstrb = 4'b0011;
        @(negedge clk);
        chk1("l0_req_ready", if0.lsu_req_ready, 1'b1);
        e.lsu = 1'b1; e.wr = 1'b1; e.addr = 32'h8000_0100; e.wdata = 32'hDEAD_BEEF;
        e.wstrb = 4'b0011; e.rdata = 32'h0;
        sb.push_back(e);
        cyc();
        if0.lsu_req_valid = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        chk1("l0_mem_en", if0.mem_en, 1'b1);
        chk1("l0_mem_wr", if0.mem_wr, 1'b1);
        chk("l0_mem_addr", if0.mem_addr, e.addr);
        chk("l0_mem_wdata", if0.mem_wdata, e.wdata);
        chk("l0_mem_wstrb", 32'(if0.mem_wstrb), 32'(e.wstrb));
        cyc();
        @(negedge clk);
        chk1("l0_resp_valid", if0.lsu_resp_valid, 1'b1);
        chk("l0_lsu_rdata", if0.lsu_rdata, e.rdata);
        chk1("l0_mem_en_after", if0.mem_en, 1'b0);

        // LAT=3 IFU read: mem_en exactly at t+4, response at t+5
        cyc();
        if3.ifu_req_valid = 1'b1; if3.ifu_addr = 32'h8000_0080;
        @(negedge clk);
        chk1("l3_req_ready", if3.ifu_req_ready, 1'b1);
        e.lsu = 1'b0; e.wr = 1'b0; e.addr = 32'h8000_0080; e.rdata = mem_model(32'h8000_0080);
        sb.push_back(e);
        cyc();
        if3.ifu_req_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk1("l3_wait_mem_en", if3.mem_en, 1'b0);
            cyc();
        end
        @(negedge clk);
        e = sb.pop_front();
        chk1("l3_mem_en", if3.mem_en, 1'b1);
        chk("l3_mem_addr", if3.mem_addr, e.addr);
        cyc();
        @(negedge clk);
        chk1("l3_resp_valid", if3.ifu_resp_valid, 1'b1);
        chk("l3_rdata", if3.ifu_rdata, e.rdata);

        // Reset pulse in WAIT drops the transaction
        cyc();
        if3.ifu_req_valid = 1'b1; if3.ifu_addr = 32'h8000_0084;
        @(negedge clk);
        chk1("l3r_req_ready", if3.ifu_req_ready, 1'b1);
        cyc();
        if3.ifu_req_valid = 1'b0;
        cyc();
        rst_n = 1'b0;
        #1;
        chk1("l3r_mem_en", if3.mem_en, 1'b0);
        chk1("l3r_mem_wr", if3.mem_wr, 1'b0);
        chk("l3r_mem_addr", if3.mem_addr, 32'h0);
        chk("l3r_ifu_rdata", if3.ifu_rdata, 32'h0);
        chk1("l3r_ifu_resp_valid", if3.ifu_resp_valid, 1'b0);
        chk1("l3r_lsu_resp_valid", if3.lsu_resp_valid, 1'b0);
        chk("l3r_req_ready", 32'({if3.ifu_req_ready, if3.lsu_req_ready}), 32'h0);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("l3r_post_quiet", 32'({if3.ifu_resp_valid, if3.mem_en}), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
